// File: rtl/p4_memwb.sv
// p4_memwb: SIMPLE mem/write-back stage; clock/reset/state/IR/DR/cond/ar in, mem_* req/ack port, stall, wb_*, flags, branch_*, out_*, halted, bus_error out; P4_MEMWB_TIMEOUT_EN adds a REQ watchdog
module p4_memwb
`ifdef P4_MEMWB_TIMEOUT_EN
  #(parameter logic [7:0] TIMEOUT = 8'd255)
`endif
(
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic [15:0] instruction_register,
  input  logic [15:0] data_register,
  input  logic [3:0]  cond,
  input  logic [15:0] ar,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [3:0]  flags,
  output logic        branch_taken,
  output logic [15:0] branch_target,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        halted,
  output logic        bus_error
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} fsm_t;
  fsm_t fsm;
  logic [15:0] dr, sdr, mdr;
  logic [3:0] cl, op3;
  logic [1:0] op1;
  logic [2:0] ra, rb;
  logic p5_d, fl_p, first, is_ld, is_st, is_li, is_b, is_bcc, is_alu;
  logic alu_wb, do_wb, do_fl, do_out, do_hlt, cc_ok, take, unused_ok;
`ifdef P4_MEMWB_TIMEOUT_EN
  logic [7:0] cnt;
`else
  assign bus_error = 1'b0;
`endif
  always_comb begin
    op1 = instruction_register[15:14];
    ra = instruction_register[13:11];
    rb = instruction_register[10:8];
    op3 = instruction_register[7:4];
    is_ld = op1 == 2'b00;
    is_st = op1 == 2'b01;
    is_li = op1 == 2'b10 && ra == 3'b000;
    is_b = op1 == 2'b10 && ra == 3'b100;
    is_bcc = op1 == 2'b10 && ra == 3'b111;
    is_alu = op1 == 2'b11;
    alu_wb = is_alu && (op3 <= 4'd4 || op3 == 4'd6 || (op3 >= 4'd8 && op3 <= 4'd12));
    do_wb = is_ld || is_li || alu_wb;
    do_fl = alu_wb || (is_alu && op3 == 4'd5);
    do_out = is_alu && op3 == 4'd13;
    do_hlt = is_alu && op3 == 4'd15;
    cc_ok = rb == 3'd0 ? flags[2] :
            rb == 3'd1 ? flags[3] ^ flags[0] :
            rb == 3'd2 ? flags[2] | (flags[3] ^ flags[0]) :
            rb == 3'd3 ? !flags[2] : 1'b0;
    take = is_b || (is_bcc && cc_ok);
    first = state == 3'd4 && !p5_d && !halted;
  end
  assign unused_ok = ^instruction_register[3:0];
  assign stall = state == 3'd3 && (is_ld || is_st) && fsm != DONE && !halted;
  assign mem_addr = dr;
  assign mem_wdata = sdr;
  assign branch_target = dr;
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm <= IDLE;
      {mem_req, mem_we, wb_en, out_valid, branch_taken, halted, p5_d, fl_p} <= '0;
      {dr, sdr, mdr, wb_data, out_data} <= '0;
      {cl, flags, wb_addr} <= '0;
`ifdef P4_MEMWB_TIMEOUT_EN
      cnt <= '0;
      bus_error <= 1'b0;
`endif
    end else begin
      p5_d <= state == 3'd4;
      if (state == 3'd2) begin
        dr <= data_register;
        cl <= cond;
        sdr <= ar;
      end
      case (fsm)
        IDLE: if (state == 3'd3 && (is_ld || is_st) && !halted) begin
          fsm <= REQ;
          mem_req <= 1'b1;
          mem_we <= is_st;
`ifdef P4_MEMWB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        REQ: if (mem_ack) begin
          fsm <= DONE;
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          if (is_ld) mdr <= mem_rdata;
        end
`ifdef P4_MEMWB_TIMEOUT_EN
        else if (cnt == TIMEOUT - 8'd1) begin
          fsm <= DONE;
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          bus_error <= 1'b1;
          if (is_ld) mdr <= '0;
        end else cnt <= cnt + 8'd1;
`endif
        DONE: if (state != 3'd3) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
      wb_en <= first && do_wb;
      out_valid <= first && do_out;
      branch_taken <= first && take;
      fl_p <= first && do_fl;
      if (first && do_wb) begin
        wb_addr <= is_ld ? ra : rb;
        wb_data <= is_ld ? mdr : dr;
      end
      if (first && do_out) out_data <= dr;
      if (fl_p) flags <= cl;
      if (first && do_hlt) halted <= 1'b1;
    end
  end
endmodule
